// File: rtl/nx_rbus_apb_master_if.sv
// Bundles the rbus request/response and APB master signals of nx_rbus_apb_master.
// The master modport is the bridge's view; slave is the view of the rbus requester and APB completer.
interface nx_rbus_apb_master_if #(
    parameter int N_RBUS_ADDR_BITS = 16,
    parameter int N_RBUS_DATA_BITS = 32
);
    logic [N_RBUS_ADDR_BITS-1:0] rbus_addr_i;
    logic                        rbus_wr_strb_i;
    logic [N_RBUS_DATA_BITS-1:0] rbus_wr_data_i;
    logic                        rbus_rd_strb_i;
    logic [N_RBUS_DATA_BITS-1:0] rbus_rd_data_o;
    logic                        rbus_ack_o;
    logic                        rbus_err_ack_o;

    logic [N_RBUS_ADDR_BITS-1:0] apb_paddr;
    logic                        apb_psel;
    logic                        apb_penable;
    logic                        apb_pwrite;
    logic [N_RBUS_DATA_BITS-1:0] apb_pwdata;
    logic [N_RBUS_DATA_BITS-1:0] apb_prdata;
    logic                        apb_pready;
    logic                        apb_pslverr;

    modport master (
        input  rbus_addr_i, rbus_wr_strb_i, rbus_wr_data_i, rbus_rd_strb_i,
        output rbus_rd_data_o, rbus_ack_o, rbus_err_ack_o,
        output apb_paddr, apb_psel, apb_penable, apb_pwrite, apb_pwdata,
        input  apb_prdata, apb_pready, apb_pslverr
    );

    modport slave (
        output rbus_addr_i, rbus_wr_strb_i, rbus_wr_data_i, rbus_rd_strb_i,
        input  rbus_rd_data_o, rbus_ack_o, rbus_err_ack_o,
        input  apb_paddr, apb_psel, apb_penable, apb_pwrite, apb_pwdata,
        output apb_prdata, apb_pready, apb_pslverr
    );
endinterface

// File: rtl/nx_rbus_apb_master.sv
// Strobe-based rbus to APB master bridge: IDLE -> SETUP -> ACCESS -> RESP, all outputs registered.
// Optional ACCESS-phase timeout is enabled by defining NX_RBUS_APB_TIMEOUT_EN.
module nx_rbus_apb_master #(
    parameter int N_RBUS_ADDR_BITS = 16,
    parameter int N_RBUS_DATA_BITS = 32,
    parameter int TIMEOUT_CYCLES   = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    nx_rbus_apb_master_if.master   bus,
    input  logic                   overlap_clr_i,
    output logic                   busy_o,
    output logic                   overlap_err_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic [N_RBUS_ADDR_BITS-1:0] ADDR_ZERO = {N_RBUS_ADDR_BITS{1'b0}};
    localparam logic [N_RBUS_DATA_BITS-1:0] DATA_ZERO = {N_RBUS_DATA_BITS{1'b0}};

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("nx_rbus_apb_master: TIMEOUT_CYCLES must be within 1..255");
    end

`ifdef NX_RBUS_APB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]                  r_tmo_cnt;
`endif

    state_t                      r_state;
    logic [N_RBUS_ADDR_BITS-1:0] r_paddr;
    logic                        r_psel;
    logic                        r_penable;
    logic                        r_pwrite;
    logic [N_RBUS_DATA_BITS-1:0] r_pwdata;
    logic [N_RBUS_DATA_BITS-1:0] r_prdata;
    logic                        r_pslverr;
    logic [N_RBUS_DATA_BITS-1:0] r_rd_data;
    logic                        r_ack;
    logic                        r_err_ack;
    logic                        r_busy;
    logic                        r_overlap;

    logic w_wr;
    logic w_rd;

    assign w_wr = bus.rbus_wr_strb_i;
    assign w_rd = bus.rbus_rd_strb_i;

    // Transfer sequencer; every bus-facing output is a register written here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_paddr   <= ADDR_ZERO;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_pwdata  <= DATA_ZERO;
            r_prdata  <= DATA_ZERO;
            r_pslverr <= 1'b0;
            r_rd_data <= DATA_ZERO;
            r_ack     <= 1'b0;
            r_err_ack <= 1'b0;
            r_busy    <= 1'b0;
`ifdef NX_RBUS_APB_TIMEOUT_EN
            r_tmo_cnt <= 8'd0;
`endif
        end else begin
            r_ack     <= 1'b0;
            r_err_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_wr && w_rd) begin
                        // Ambiguous direction: reject without touching the APB side.
                        r_err_ack <= 1'b1;
                        r_rd_data <= DATA_ZERO;
                    end else if (w_wr || w_rd) begin
                        r_paddr   <= bus.rbus_addr_i;
                        r_pwrite  <= w_wr;
                        r_pwdata  <= w_wr ? bus.rbus_wr_data_i : DATA_ZERO;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_SETUP;
                    end else begin
                        r_state   <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    r_penable <= 1'b1;
`ifdef NX_RBUS_APB_TIMEOUT_EN
                    r_tmo_cnt <= 8'd0;
`endif
                    r_state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (bus.apb_pready) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_prdata  <= r_pwrite ? DATA_ZERO : bus.apb_prdata;
                        r_pslverr <= bus.apb_pslverr;
                        r_state   <= ST_RESP;
                    end
`ifdef NX_RBUS_APB_TIMEOUT_EN
                    else if (r_tmo_cnt == TMO_LAST) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_prdata  <= DATA_ZERO;
                        r_pslverr <= 1'b1;
                        r_state   <= ST_RESP;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 8'd1;
                    end
`else
                    else begin
                        r_state <= ST_ACCESS;
                    end
`endif
                end
                ST_RESP: begin
                    if (r_pslverr) begin
                        r_err_ack <= 1'b1;
                        r_rd_data <= DATA_ZERO;
                    end else begin
                        r_ack     <= 1'b1;
                        r_rd_data <= r_prdata;
                    end
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky overlap flag: a strobe while busy sets it, and a set beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overlap <= 1'b0;
        end else if ((r_state != ST_IDLE) && (w_wr || w_rd)) begin
            r_overlap <= 1'b1;
        end else if (overlap_clr_i) begin
            r_overlap <= 1'b0;
        end else begin
            r_overlap <= r_overlap;
        end
    end

    assign bus.apb_paddr      = r_paddr;
    assign bus.apb_psel       = r_psel;
    assign bus.apb_penable    = r_penable;
    assign bus.apb_pwrite     = r_pwrite;
    assign bus.apb_pwdata     = r_pwdata;
    assign bus.rbus_rd_data_o = r_rd_data;
    assign bus.rbus_ack_o     = r_ack;
    assign bus.rbus_err_ack_o = r_err_ack;
    assign busy_o             = r_busy;
    assign overlap_err_o      = r_overlap;

endmodule
